// File: rtl/ifid_fetch_queue.sv
// ifid_fetch_queue: IF/ID instruction queue, circular buffer with first-word fall-through.
module ifid_fetch_queue #(
    parameter int             IW    = 32,
    parameter int             PW    = 32,
    parameter int             DEPTH = 4,
    parameter logic [IW-1:0]  NOP   = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [IW-1:0]            push_instr,
    input  logic [PW-1:0]            push_pcplus4,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [IW-1:0]            pop_instr,
    output logic [PW-1:0]            pop_pcplus4,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [IW-1:0] instr_q [DEPTH];
    logic [PW-1:0] pc_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_fire, pop_fire;

    always_comb begin
        push_ready  = count_q != CW'(DEPTH);
        pop_valid   = count_q != '0;
        push_fire   = push_valid & push_ready & ~flush & reset;
        pop_fire    = pop_valid & pop_ready & ~flush;
        wptr_d      = flush ? '0 : wptr_q + AW'(push_fire);
        rptr_d      = flush ? '0 : rptr_q + AW'(pop_fire);
        count_d     = flush ? '0 : count_q + CW'(push_fire) - CW'(pop_fire);
        // Gating on count hides stale storage whenever the queue is empty.
        pop_instr   = pop_valid ? instr_q[rptr_q] : NOP;
        pop_pcplus4 = pop_valid ? pc_q[rptr_q] : '0;
        count       = count_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            instr_q[wptr_q] <= push_instr;
            pc_q[wptr_q]    <= push_pcplus4;
        end
    end
endmodule

// File: tb/tb_ifid_fetch_queue.sv
// tb_ifid_fetch_queue: vector table plus data scoreboard for the fetch queue.
module tb_ifid_fetch_queue;
    logic        clk = 0, reset = 0;
    logic        push_valid = 0, pop_ready = 0, flush = 0;
    logic [31:0] push_instr = '0, push_pcplus4 = '0;
    logic        push_ready, pop_valid;
    logic [31:0] pop_instr, pop_pcplus4;
    logic [2:0]  count;
    int          checks = 0, errors = 0;
    logic [63:0] sb[$];

    typedef struct {
        logic        pv, pr, fl;
        logic [31:0] ins, pc;
        int          cnt;
    } vec_t;
    vec_t vt[20];

    ifid_fetch_queue #(.IW(32), .PW(32), .DEPTH(4), .NOP(32'h0000_0013)) dut (
        .clk(clk), .reset(reset), .push_valid(push_valid), .push_ready(push_ready),
        .push_instr(push_instr), .push_pcplus4(push_pcplus4), .pop_valid(pop_valid),
        .pop_ready(pop_ready), .pop_instr(pop_instr), .pop_pcplus4(pop_pcplus4),
        .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_head(input string tag);
        if (sb.size() != 0) begin
            chk({tag, " instr"}, pop_instr, sb[0][63:32]);
            chk({tag, " pc"}, pop_pcplus4, sb[0][31:0]);
        end else begin
            chk({tag, " nop"}, pop_instr, 32'h0000_0013);
            chk({tag, " pc0"}, pop_pcplus4, 0);
        end
        chk({tag, " pop_valid"}, pop_valid, sb.size() != 0);
    endtask

    task automatic apply(input vec_t v, input int idx);
        bit pf, of;
        push_valid = v.pv; pop_ready = v.pr; flush = v.fl;
        push_instr = v.ins; push_pcplus4 = v.pc;
        #1;
        chk_head($sformatf("v%0d pre", idx));
        pf = v.pv && sb.size() != 4 && !v.fl;
        of = v.pr && sb.size() != 0 && !v.fl;
        if (v.fl) sb.delete();
        if (of) void'(sb.pop_front());
        if (pf) sb.push_back({v.ins, v.pc});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d count", idx), count, v.cnt);
        chk($sformatf("v%0d push_ready", idx), push_ready, v.cnt != 4);
        chk_head($sformatf("v%0d post", idx));
    endtask

    initial begin
        vt[0]  = '{1, 0, 0, 32'h11111111, 32'h4,  1};
        vt[1]  = '{1, 0, 0, 32'h22222222, 32'h8,  2};
        vt[2]  = '{1, 0, 0, 32'h33333333, 32'hC,  3};
        vt[3]  = '{1, 0, 0, 32'h44444444, 32'h10, 4};
        vt[4]  = '{1, 0, 0, 32'h55555555, 32'h14, 4};
        vt[5]  = '{1, 1, 0, 32'h55555555, 32'h14, 3};
        vt[6]  = '{1, 0, 0, 32'h55555555, 32'h14, 4};
        vt[7]  = '{0, 1, 0, 32'h0,        32'h0,  3};
        vt[8]  = '{0, 1, 0, 32'h0,        32'h0,  2};
        vt[9]  = '{1, 1, 0, 32'h66666666, 32'h18, 2};
        vt[10] = '{1, 1, 0, 32'h77777777, 32'h1C, 2};
        vt[11] = '{1, 1, 0, 32'h88888888, 32'h20, 2};
        vt[12] = '{1, 1, 0, 32'h99999999, 32'h24, 2};
        vt[13] = '{1, 1, 0, 32'hAAAAAAAA, 32'h28, 2};
        vt[14] = '{1, 1, 0, 32'hBBBBBBBB, 32'h2C, 2};
        vt[15] = '{1, 0, 0, 32'hCCCCCCCC, 32'h30, 3};
        vt[16] = '{1, 0, 1, 32'hDEADBEEF, 32'h34, 0};
        vt[17] = '{0, 1, 0, 32'h0,        32'h0,  0};
        vt[18] = '{1, 1, 0, 32'h12345678, 32'h38, 1};
        vt[19] = '{0, 1, 0, 32'h0,        32'h0,  0};

        #2;
        chk("reset count", count, 0);
        chk("reset push_ready", push_ready, 1);
        chk_head("reset");
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) apply(vt[i], i);

        apply('{1, 0, 0, 32'h0BAD0001, 32'h40, 1}, 20);
        apply('{1, 0, 0, 32'h0BAD0002, 32'h44, 2}, 21);
        push_valid = 0;
        #3;
        reset = 0;
        sb.delete();
        #1;
        chk("midreset count", count, 0);
        chk("midreset push_ready", push_ready, 1);
        chk_head("midreset");
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
        apply('{1, 0, 0, 32'hABCD0000, 32'h48, 1}, 22);
        chk("after reset instr", pop_instr, 32'hABCD0000);
        apply('{0, 1, 0, 32'h0, 32'h0, 0}, 23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifid_fetch_queue.md
IFID_FETCH_QUEUE -- requirements
Module: ifid_fetch_queue

Interface
REQ-001 Parameter IW, default 32, instruction word width in bits.
REQ-002 Parameter PW, default 32, PC+4 word width in bits.
REQ-003 Parameter DEPTH, default 4, entry count; power of 2, minimum 2.
REQ-004 Parameter NOP, default 0 (IW bits), instruction word presented when the queue is empty.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 push_valid  input  1  fetch stage offers an instruction this cycle.
REQ-008 push_ready  output  1  queue can accept an entry this cycle.
REQ-009 push_instr  input  IW  fetched instruction word.
REQ-010 push_pcplus4  input  PW  PC+4 of the fetched instruction.
REQ-011 pop_valid  output  1  head entry is valid.
REQ-012 pop_ready  input  1  decode stage consumes the head entry (not stalled).
REQ-013 pop_instr  output  IW  head instruction word, or NOP when empty.
REQ-014 pop_pcplus4  output  PW  head PC+4, or all zeros when empty.
REQ-015 flush  input  1  discard all entries (taken branch, jump, jr).
REQ-016 count  output  clog2(DEPTH)+1  number of valid entries.

Function
REQ-017 Storage: circular buffer of DEPTH entries; each entry holds {instr, pcplus4}; read and write pointers are clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-018 push_ready = (count < DEPTH); it depends only on registered state, not on pop_ready in the same cycle.
REQ-019 Push fire = push_valid & push_ready & ~flush; on fire, the entry is written at the write pointer, and the write pointer increments at the edge.
REQ-020 pop_valid = (count != 0); pop_instr and pop_pcplus4 show the head entry combinationally from storage (first-word fall-through).
REQ-021 Pop fire = pop_valid & pop_ready & ~flush; on fire, the read pointer increments at the edge.
REQ-022 Latency: an entry pushed at edge N is visible on the pop outputs immediately after edge N; there is no same-cycle bypass when the queue is empty.
REQ-023 A simultaneous push fire and pop fire leaves count unchanged, and both pointers advance.
REQ-024 count: +1 on push fire only, -1 on pop fire only, unchanged otherwise; count never exceeds DEPTH and never goes below 0.
REQ-025 Full (count == DEPTH): push_ready = 0, and push_valid is ignored even if a pop fires in the same cycle.
REQ-026 Empty (count == 0): pop_valid = 0, pop_instr = NOP, pop_pcplus4 = 0, and pop_ready is ignored.
REQ-027 Flush has priority over push and pop: at the edge, both pointers return to 0 and count to 0; the same-cycle push is dropped and not written.
REQ-028 Occupancy states: EMPTY (count == 0), PARTIAL (0 < count < DEPTH), FULL (count == DEPTH). Transitions follow REQ-024 and REQ-027 only; a flush from any state goes to EMPTY.
REQ-029 Storage contents need no reset; only pointers and count are reset, and outputs must never expose stale data while count == 0.

Reset
REQ-030 While reset = 0: pointers = 0, count = 0, push_ready = 1, pop_valid = 0, pop_instr = NOP, pop_pcplus4 = 0, all asynchronously, without waiting for clk.
REQ-031 Reset asserted mid-operation discards all entries immediately; after release, the first push fire is stored at entry 0.
REQ-032 No push or pop fires on the first rising edge coincident with reset deassertion if reset is still sampled low.

Verification
REQ-033 DEPTH=4, push 0x11111111, 0x22222222, 0x33333333 with pcplus4 0x4, 0x8, 0xC, pop_ready=0 -> count=3; pop_instr=0x11111111, pop_pcplus4=0x4.
REQ-034 Push 5 words with pop_ready=0 -> after 4 pushes count=4 and push_ready=0; the 5th is held off; pop order is 1,2,3,4.
REQ-035 Full queue, push_valid=1 and pop_ready=1 for one cycle -> one pop only, count=3, push rejected; the next cycle accepts the push and count returns to 4.
REQ-036 count=2, push and pop both fire for 6 cycles -> count stays 2, pointers wrap past 3, and data order is preserved.
REQ-037 count=3, flush=1 with push_valid=1 -> next cycle count=0, pop_instr=NOP, and the pushed word is never popped.
REQ-038 count=2, reset driven low between clock edges -> count=0, pop_valid=0 before the next edge; after release, push 0xABCD0000 -> pop_instr=0xABCD0000.
